// File: rtl/mem_responder.sv
// mem_responder: single-outstanding RAM/ROM responder with programmable wait states.
// ROM image comes from ROM_INIT (byte k at bits 8k+7:8k). Optional MEM_RESPONDER_PIPE_EN gives bubble-free back-to-back requests.
module mem_responder #(
  parameter int                       RAM_AW   = 12,
  parameter int                       ROM_AW   = 10,
  parameter logic [15:0]              ROM_BASE = 16'h8000,
  parameter int                       WAIT_CYC = 1,
  parameter logic [8*(2**ROM_AW)-1:0] ROM_INIT = '0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [15:0] req_a,
  input  logic [7:0]  req_d,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [7:0]  rsp_q,
  output logic [7:0]  rsp_q1,
  output logic [7:0]  rsp_q2,
  output logic [7:0]  rsp_q3,
  output logic        rsp_err
);

  localparam int              RAM_SIZE    = 2**RAM_AW;
  localparam int              ROM_SIZE    = 2**ROM_AW;
  localparam logic [16:0]     RAM_END     = 17'(RAM_SIZE);
  localparam logic [16:0]     ROM_END     = {1'b0, ROM_BASE} + 17'(ROM_SIZE);
  localparam logic [ROM_AW-1:0] ROM_BASE_LO = ROM_BASE[ROM_AW-1:0];
  localparam logic [3:0]      CNT_INIT    = (WAIT_CYC > 0) ? 4'(WAIT_CYC - 1) : 4'd0;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic [3:0]  r_cnt;
  logic [3:0]  w_cnt_next;
  logic        w_req_ready;
  logic        w_rsp_valid;
  logic        w_accept;
  logic        w_access;

  logic        r_we;
  logic [15:0] r_a;
  logic [7:0]  r_d;

  logic        w_acc_we;
  logic [15:0] w_acc_a;
  logic [7:0]  w_acc_d;
  logic        w_is_ram;
  logic        w_is_rom;
  logic [RAM_AW-1:0] w_ram_idx;
  logic [ROM_AW-1:0] w_rom_off;
  logic        w_ram_wr;
  logic        w_ram_rd;

  logic [7:0]  r_ram [RAM_SIZE];
  logic [7:0]  r_ram_q;
  logic [7:0]  w_rom [ROM_SIZE];

  logic [7:0]  r_q;
  logic [7:0]  r_q1;
  logic [7:0]  r_q2;
  logic [7:0]  r_q3;
  logic        r_err;
  logic        r_sel_ram;

  for (genvar gi = 0; gi < ROM_SIZE; gi++) begin : g_rom
    assign w_rom[gi] = ROM_INIT[8*gi +: 8];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_req_ready  = 1'b0;
    w_rsp_valid  = 1'b0;
    w_access     = 1'b0;
    w_accept     = 1'b0;
    case (r_state)
      IDLE: w_req_ready = 1'b1;
      WAIT: begin
        if (r_cnt == 4'd0) begin
          w_access     = 1'b1;
          w_state_next = RESP;
        end else begin
          w_cnt_next = r_cnt - 4'd1;
        end
      end
      RESP: begin
        w_rsp_valid = 1'b1;
        if (rsp_ready) w_state_next = IDLE;
`ifdef MEM_RESPONDER_PIPE_EN
        w_req_ready = rsp_ready;
`endif
      end
      default: w_state_next = IDLE;
    endcase
    // An accept overrides whatever the current state decided (covers the pipelined RESP case)
    w_accept = req_valid && w_req_ready;
    if (w_accept) begin
      if (WAIT_CYC == 0) begin
        w_access     = 1'b1;
        w_state_next = RESP;
      end else begin
        w_state_next = WAIT;
        w_cnt_next   = CNT_INIT;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_we <= 1'b0;
      r_a  <= '0;
      r_d  <= '0;
    end else if (w_accept) begin
      r_we <= req_we;
      r_a  <= req_a;
      r_d  <= req_d;
    end
  end

  // With zero wait states the access happens on the accept edge, straight from the inputs
  assign w_acc_we  = (r_state == WAIT) ? r_we : req_we;
  assign w_acc_a   = (r_state == WAIT) ? r_a  : req_a;
  assign w_acc_d   = (r_state == WAIT) ? r_d  : req_d;

  assign w_is_ram  = ({1'b0, w_acc_a} < RAM_END);
  assign w_is_rom  = (w_acc_a >= ROM_BASE) && ({1'b0, w_acc_a} < ROM_END);
  assign w_ram_idx = w_acc_a[RAM_AW-1:0];
  assign w_rom_off = w_acc_a[ROM_AW-1:0] - ROM_BASE_LO;
  assign w_ram_wr  = w_access && w_is_ram && w_acc_we && !rst;
  assign w_ram_rd  = w_access && w_is_ram && !w_acc_we && !rst;

  always_ff @(posedge clk) begin
    if (w_ram_wr) r_ram[w_ram_idx] <= w_acc_d;
    if (w_ram_rd) r_ram_q <= r_ram[w_ram_idx];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q       <= '0;
      r_q1      <= '0;
      r_q2      <= '0;
      r_q3      <= '0;
      r_err     <= 1'b0;
      r_sel_ram <= 1'b0;
    end else if (w_access) begin
      r_q       <= '0;
      r_q1      <= '0;
      r_q2      <= '0;
      r_q3      <= '0;
      r_err     <= 1'b0;
      r_sel_ram <= 1'b0;
      if (w_is_ram) begin
        r_sel_ram <= !w_acc_we;
      end else if (w_is_rom) begin
        if (w_acc_we) begin
          r_err <= 1'b1;
        end else begin
          // Offset arithmetic is ROM_AW bits wide, so a fetch near the top wraps to offset 0
          r_q  <= w_rom[w_rom_off];
          r_q1 <= w_rom[w_rom_off + ROM_AW'(1)];
          r_q2 <= w_rom[w_rom_off + ROM_AW'(2)];
          r_q3 <= w_rom[w_rom_off + ROM_AW'(3)];
        end
      end else begin
        r_err <= 1'b1;
      end
    end
  end

  assign req_ready = w_req_ready;
  assign rsp_valid = w_rsp_valid;
  assign rsp_q     = r_sel_ram ? r_ram_q : r_q;
  assign rsp_q1    = r_q1;
  assign rsp_q2    = r_q2;
  assign rsp_q3    = r_q3;
  assign rsp_err   = r_err;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: RAM/ROM/unmapped decode, wait-state latency,
// response hold, async reset behaviour and back-to-back throughput.
module tb_mem_responder;

  localparam int          WC = 1;
  localparam logic [15:0] RB = 16'h8000;
  localparam logic [8191:0] ROM_IMG = {8'hBB, 8'hAA, {1018{8'h00}}, 8'h44, 8'h33, 8'h22, 8'h11};
`ifdef MEM_RESPONDER_PIPE_EN
  localparam int B2B_CYC = 2 * (WC + 1);
`else
  localparam int B2B_CYC = 2 * (WC + 1) + 1;
`endif

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [15:0] req_a;
  logic [7:0]  req_d;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [7:0]  rsp_q;
  logic [7:0]  rsp_q1;
  logic [7:0]  rsp_q2;
  logic [7:0]  rsp_q3;
  logic        rsp_err;

  int n_checks;
  int n_fail;
  int n;
  int startk;
  int endk;
  int nacc;
  int ncons;
  logic acc;
  logic cons;
  logic [7:0] rq0;
  logic [7:0] rq1;

  mem_responder #(
    .RAM_AW  (12),
    .ROM_AW  (10),
    .ROM_BASE(RB),
    .WAIT_CYC(WC),
    .ROM_INIT(ROM_IMG)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_we   (req_we),
    .req_a    (req_a),
    .req_d    (req_d),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_q    (rsp_q),
    .rsp_q1   (rsp_q1),
    .rsp_q2   (rsp_q2),
    .rsp_q3   (rsp_q3),
    .rsp_err  (rsp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Called at a falling edge; returns at a falling edge after the response is consumed.
  task automatic txn(input string tag, input logic we, input logic [15:0] a, input logic [7:0] d,
                     input logic [31:0] exp_q, input logic exp_err, input int hold);
    int w;
    int lat;
    req_valid = 1'b1;
    req_we    = we;
    req_a     = a;
    req_d     = d;
    w = 0;
    while (!req_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    check({tag, "_accept"}, {31'd0, req_ready}, 32'd1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_we    = ~we;
    req_a     = ~a;
    req_d     = ~d;
    lat = 1;
    while (!rsp_valid && lat < 50) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check({tag, "_lat"}, lat, WC + 1);
    check({tag, "_q"}, {rsp_q, rsp_q1, rsp_q2, rsp_q3}, exp_q);
    check({tag, "_err"}, {31'd0, rsp_err}, {31'd0, exp_err});
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check({tag, "_hold_valid"}, {31'd0, rsp_valid}, 32'd1);
      check({tag, "_hold_q"}, {rsp_q, rsp_q1, rsp_q2, rsp_q3}, exp_q);
      check({tag, "_hold_err"}, {31'd0, rsp_err}, {31'd0, exp_err});
      check({tag, "_hold_rdy"}, {31'd0, req_ready}, 32'd0);
    end
    $display("txn %s we=%0d a=%h d=%h -> q=%h %h %h %h err=%0d lat=%0d",
             tag, we, a, d, rsp_q, rsp_q1, rsp_q2, rsp_q3, rsp_err, lat);
    @(negedge clk);
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    rst       = 1'b1;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_a     = '0;
    req_d     = '0;
    rsp_ready = 1'b0;
    #12;
    check("rst_ready", {31'd0, req_ready}, 32'd1);
    check("rst_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst_data", {rsp_q, rsp_q1, rsp_q2, rsp_q3}, 32'd0);
    check("rst_err", {31'd0, rsp_err}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Async reset mid-cycle while a response is held
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_a     = RB;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    n = 0;
    while (!rsp_valid && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("pre_rst_q", {rsp_q, rsp_q1, rsp_q2, rsp_q3}, 32'h11223344);
    #2 rst = 1'b1;
    #1;
    check("arst_ready", {31'd0, req_ready}, 32'd1);
    check("arst_valid", {31'd0, rsp_valid}, 32'd0);
    check("arst_data", {rsp_q, rsp_q1, rsp_q2, rsp_q3}, 32'd0);
    check("arst_err", {31'd0, rsp_err}, 32'd0);
    #2 rst = 1'b0;
    @(negedge clk);

    // RAM store then load
    txn("st10", 1'b1, 16'h0010, 8'hA5, 32'h0, 1'b0, 0);
    txn("ld10", 1'b0, 16'h0010, 8'h00, 32'hA5000000, 1'b0, 0);

    // ROM loads including wrap at the top of ROM
    txn("ldrom0", 1'b0, RB, 8'h00, 32'h11223344, 1'b0, 0);
    txn("ldrom1", 1'b0, RB + 16'h0001, 8'h00, 32'h22334400, 1'b0, 0);
    txn("ldrom3fe", 1'b0, RB + 16'h03FE, 8'h00, 32'hAABB1122, 1'b0, 0);
    txn("ldrom3ff", 1'b0, RB + 16'h03FF, 8'h00, 32'hBB112233, 1'b0, 0);

    // ROM store and unmapped accesses
    txn("strom", 1'b1, RB, 8'h5A, 32'h0, 1'b1, 0);
    txn("ldrom0b", 1'b0, RB, 8'h00, 32'h11223344, 1'b0, 0);
    txn("ld4000", 1'b0, 16'h4000, 8'h00, 32'h0, 1'b1, 0);
    txn("st1010", 1'b1, 16'h1010, 8'h99, 32'h0, 1'b1, 0);
    txn("ld10b", 1'b0, 16'h0010, 8'h00, 32'hA5000000, 1'b0, 0);

    // Region boundaries
    txn("stfff", 1'b1, 16'h0FFF, 8'hC3, 32'h0, 1'b0, 0);
    txn("ldfff", 1'b0, 16'h0FFF, 8'h00, 32'hC3000000, 1'b0, 0);
    txn("ld1000", 1'b0, 16'h1000, 8'h00, 32'h0, 1'b1, 0);
    txn("ld7fff", 1'b0, 16'h7FFF, 8'h00, 32'h0, 1'b1, 0);
    txn("ld8400", 1'b0, 16'h8400, 8'h00, 32'h0, 1'b1, 0);

    // Response held for 5 cycles, then ready again the cycle after consume
    txn("hold", 1'b0, 16'h0010, 8'h00, 32'hA5000000, 1'b0, 5);
    check("post_ready", {31'd0, req_ready}, 32'd1);
    check("post_valid", {31'd0, rsp_valid}, 32'd0);

    // Reset during WAIT drops the store
    txn("st20", 1'b1, 16'h0020, 8'h3C, 32'h0, 1'b0, 0);
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_a     = 16'h0020;
    req_d     = 8'h77;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    rst = 1'b1;
    #2;
    check("wrst_valid", {31'd0, rsp_valid}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    txn("ld20", 1'b0, 16'h0020, 8'h00, 32'h3C000000, 1'b0, 0);

    // Two loads with requests and rsp_ready held high
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_a     = 16'h0010;
    rsp_ready = 1'b1;
    nacc = 0;
    ncons = 0;
    startk = 0;
    endk = -1;
    rq0 = '0;
    rq1 = '0;
    for (int k = 0; k < 40 && ncons < 2; k++) begin
      acc  = req_valid && req_ready;
      cons = rsp_valid && rsp_ready;
      if (cons) begin
        if (ncons == 0) rq0 = rsp_q;
        else rq1 = rsp_q;
        ncons++;
        endk = k;
      end
      if (acc) begin
        if (nacc == 0) startk = k;
        nacc++;
      end
      @(posedge clk);
      #1;
      if (acc) begin
        if (nacc == 1) req_a = RB;
        else req_valid = 1'b0;
      end
      @(negedge clk);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b0;
    $display("txn b2b cycles=%0d q0=%h q1=%h", endk - startk, rq0, rq1);
    check("b2b_cycles", endk - startk, B2B_CYC);
    check("b2b_q0", {24'd0, rq0}, 32'hA5);
    check("b2b_q1", {24'd0, rq1}, 32'h11);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
